spectrum_buffer_arbiter: RTL

SPECTRUM_BUFFER_ARBITER -- requirements
Module: spectrum_buffer_arbiter

---
 rtl/spectrum_buffer_arbiter_pkg.sv | 15 +
 rtl/spectrum_buffer_arbiter_if.sv | 25 ++
 rtl/spectrum_buffer_arbiter_bank_ram.sv | 20 ++
 rtl/spectrum_buffer_arbiter.sv | 106 ++++++++++
 4 files changed

// File: rtl/spectrum_buffer_arbiter_pkg.sv
// Shared types and defaults for the double-buffered spectrum display arbiter.
package sba_pkg;
  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W      = 16;

  typedef enum logic {
    FILL    = 1'b0,
    PENDING = 1'b1
  } sba_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/spectrum_buffer_arbiter_if.sv
// Producer write handshake plus display read bus of the spectrum buffer arbiter.
interface spectrum_buffer_arbiter_if
  import sba_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_last;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_last, rd_addr,
    input  wr_ready, rd_data
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_last, rd_addr,
    output wr_ready, rd_data
  );
endinterface

// File: rtl/spectrum_buffer_arbiter_bank_ram.sv
// One spectrum bank: simple dual-port RAM, one write port, registered read port.
module sba_bank_ram #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: no reset on the array or its read register, so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/spectrum_buffer_arbiter.sv
// Ping-pong spectrum buffer: producer fills the hidden bank, display swaps on vsync.
// Optional statistics ports/counters are enabled by defining SPECTRUM_BUFFER_STATS_EN.
module spectrum_buffer_arbiter
  import sba_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  spectrum_buffer_arbiter_if.slave  bus,
  input  logic                      vsync_n,
  output logic                      disp_bank,
  output logic                      pending,
  output logic                      frame_swap
`ifdef SPECTRUM_BUFFER_STATS_EN
  ,
  output logic [CNT_W-1:0]          swap_cnt,
  output logic [CNT_W-1:0]          repeat_cnt
`endif
);
  sba_state_e        state, state_nxt;
  logic              vsync_q;
  logic              swap_evt;
  logic              wr_en;
  logic              disp_bank_q;
  logic              rd_vld;
  logic [DATA_W-1:0] rd_data0, rd_data1;

  assign swap_evt = vsync_q & ~vsync_n;
  assign wr_en    = bus.wr_valid & bus.wr_ready;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  // NOTE: default assignment first so no path through the case leaves a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL:    if (wr_en && bus.wr_last) state_nxt = PENDING;
      PENDING: if (swap_evt)             state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_comb begin
    bus.wr_ready = (state == FILL) && !rst;
    pending      = (state == PENDING);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q     <= 1'b1;
      disp_bank   <= 1'b0;
      frame_swap  <= 1'b0;
      disp_bank_q <= 1'b0;
      rd_vld      <= 1'b0;
    end else begin
      vsync_q     <= vsync_n;
      frame_swap  <= (state == PENDING) && swap_evt;
      if ((state == PENDING) && swap_evt) disp_bank <= ~disp_bank;
      disp_bank_q <= disp_bank;
      rd_vld      <= 1'b1;
    end
  end

  // The write bank is always the one not on display.
  sba_bank_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank0 (
    .clk   (clk),
    .we    (wr_en & disp_bank),
    .waddr (bus.wr_addr),
    .wdata (bus.wr_data),
    .raddr (bus.rd_addr),
    .rdata (rd_data0)
  );

  sba_bank_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank1 (
    .clk   (clk),
    .we    (wr_en & ~disp_bank),
    .waddr (bus.wr_addr),
    .wdata (bus.wr_data),
    .raddr (bus.rd_addr),
    .rdata (rd_data1)
  );

  // Mux on the bank that was displayed when the read was issued; zero until the first read.
  always_comb begin
    bus.rd_data = '0;
    if (rd_vld) bus.rd_data = disp_bank_q ? rd_data1 : rd_data0;
  end

`ifdef SPECTRUM_BUFFER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      swap_cnt   <= '0;
      repeat_cnt <= '0;
    end else if (swap_evt) begin
      if (state == PENDING) swap_cnt   <= sat_inc(swap_cnt);
      else                  repeat_cnt <= sat_inc(repeat_cnt);
    end
  end
`endif
endmodule
